text_buffer_ctrl: RTL and testbench
===================================

// Module: text_buffer_ctrl
// PURPOSE
// Owns the character buffer behind the centred text window: 32 cols x 4 rows of 8x16 glyphs at x 192..447, y 208..271.
// Accepts characters from an input source (keyboard/UART decoder) over a valid/ready handshake.
// Maintains the cursor and applies control codes: backspace, newline, clear, wrap.
// Translates the renderer's pixel (x,y) into the ascii_code feeding the glyph-ROM path. Bit 7 selects the Thai ROM.
// PARAMETERS
// COLS       32          characters per row (power of 2)
// ROWS       4           rows (power of 2)
// X0         192         left pixel of window
// Y0         208         top pixel of window
// BLINK_DIV  12_500_000  clk cycles per cursor blink half-period (sim: 4)
// PORTS
// clk         in   1   system clock
// reset       in   1   asynchronous, active-high reset
// char_in     in   8   character/command code
// char_valid  in   1   char_in valid
// char_ready  out  1   block can accept char_in this cycle
// busy        out  1   clear sequence in progress
// x           in   10  current pixel column
// y           in   10  current pixel row
// ascii_code  out  8   code for cell under (x,y), registered
// cursor_col  out  5   cursor column (clog2(COLS))
// cursor_row  out  2   cursor row (clog2(ROWS))
// BEHAVIOUR
// - Storage: COLS*ROWS x 8 RAM with one write port and one read port. The cell index is row*COLS+col.
// - Reset values: cursor (0,0); ascii_code 8'h20; blink counter and phase 0; char_ready 0; busy 1.
// - Reset forces the FSM into CLR_ALL. RAM contents are never reset directly.
// - FSM states:
//   IDLE: char_ready=1. A transfer occurs when char_valid && char_ready on a rising clk edge.
//   CLR_ALL: writes 8'h20 to index 0..COLS*ROWS-1, one per cycle, then returns to IDLE.
//   CLR_ROW: writes 8'h20 to the COLS cells of cursor_row, then returns to IDLE.
//   char_ready=0 and busy=1 in both clear states. char_in is ignored while char_ready=0.
// - Decoding of an accepted code (RAM write and cursor update happen on the accept edge):
//   8'h20..8'h7E and 8'h80..8'hFF: write the code at the cursor, then advance the cursor.
//   8'h08 backspace:
//     at (0,0): no-op.
//     col>0: cursor moves to (row, col-1) and that cell gets 8'h20.
//     col==0: cursor moves to (row-1, COLS-1) and that cell gets 8'h20.
//   8'h0D newline: col=0, row advances.
//   8'h0C clear: cursor to (0,0), enter CLR_ALL.
//   All other codes (8'h00..8'h1F except the above, 8'h7F): accepted, no effect.
// - Advance: col+1. At col==COLS-1: col=0 and the row advances.
// - Row advance: row+1. At row==ROWS-1: row=0 and the FSM enters CLR_ROW for row 0.
// - Read path, registered, 1-clk latency from (x,y):
//   Inside window: col=(x-X0)>>3, row=(y-Y0)>>4, ascii_code=RAM[row*COLS+col].
//   Outside window: ascii_code=8'h20.
//   Cursor cell with blink phase=1 and cell==8'h20: ascii_code=8'h5F.
//   A read and a write to the same cell in one cycle returns the old data.
// - Blink: counter counts 0..BLINK_DIV-1 and toggles phase on wrap. It runs in every state.
// - Reset asserted mid-clear restarts CLR_ALL at index 0 when released.
// TESTING
// 1. Release reset: char_ready=0 and busy=1 for exactly 128 clks, then char_ready=1. Every window cell reads 8'h20 (cursor cell excepted).
// 2. Send 8'h41 at (0,0): cursor becomes (0,1). Drive x=192,y=208: ascii_code=8'h41 one clk later. Send 8'hA1: cell (0,1)=8'hA1.
// 3. Send 32 x 8'h41, then 8'h42: 8'h42 lands at (1,0) and cursor becomes (1,1). Send 8'h0D: cursor becomes (2,0).
// 4. Cursor at (3,31), send 8'h43: cursor becomes (0,0), busy=1 for 32 clks, row 0 reads all 8'h20, rows 1..3 unchanged.
// 5. Backspace at (1,0): cursor becomes (0,31) and that cell is 8'h20. Backspace at (0,0): cursor and RAM unchanged.
// 6. BLINK_DIV=4, idle cursor on a blank cell: ascii_code at the cursor cell alternates 8'h20/8'h5F every 4 clks.
// 7. Send 8'h0C, then assert reset on clear cycle 50: after release, busy=1 for a full 128 clks and the cursor is (0,0).

Source files
------------

// File: rtl/text_buffer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | text_buffer_ctrl: character RAM, cursor/control-code FSM, pixel readout  |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module text_buffer_ctrl #(
  parameter int COLS      = 32,
  parameter int ROWS      = 4,
  parameter int X0        = 192,
  parameter int Y0        = 208,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               char_in,
  input  logic                     char_valid,
  output logic                     char_ready,
  output logic                     busy,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  output logic [7:0]               ascii_code,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic [$clog2(ROWS)-1:0]  cursor_row
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = CW + RW;
  localparam int N  = COLS * ROWS;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ALL = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic [7:0]      mem [N];
  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;
  logic [AW-1:0]   cur_idx;
  logic            accept;
  logic            printable;
  logic            col_max;
  logic            row_max;
  logic            row_adv;

  assign cur_idx   = {cursor_row, cursor_col};
  assign accept    = char_valid && char_ready;
  assign printable = (char_in >= 8'h20) && (char_in != 8'h7F);
  assign col_max   = (cursor_col == CW'(COLS - 1));
  assign row_max   = (cursor_row == RW'(ROWS - 1));
  assign row_adv   = (char_in == 8'h0D) || (printable && col_max);

  // Single write port: clear sweeps own it, otherwise the accepted code does.
  always_comb begin
    we    = 1'b0;
    waddr = clr_idx;
    wdata = 8'h20;
    case (state)
      CLR_ALL: we = 1'b1;
      CLR_ROW: begin
        we    = 1'b1;
        waddr = {cursor_row, clr_idx[CW-1:0]};
      end
      default: begin
        if (accept) begin
          if (printable) begin
            we    = 1'b1;
            waddr = cur_idx;
            wdata = char_in;
          end else if (char_in == 8'h08 && cur_idx != '0) begin
            we    = 1'b1;
            waddr = cur_idx - AW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLR_ALL;
      clr_idx    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      char_ready <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        CLR_ALL: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(N - 1)) begin
            state      <= IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        CLR_ROW: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx[CW-1:0] == CW'(COLS - 1)) begin
            state      <= IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        IDLE: begin
          if (accept) begin
            if (char_in == 8'h0C) begin
              cursor_col <= '0;
              cursor_row <= '0;
              clr_idx    <= '0;
              state      <= CLR_ALL;
              char_ready <= 1'b0;
              busy       <= 1'b1;
            end else if (char_in == 8'h08) begin
              if (cur_idx != '0) {cursor_row, cursor_col} <= cur_idx - AW'(1);
            end else if (printable && !col_max) begin
              cursor_col <= cursor_col + CW'(1);
            end else if (row_adv) begin
              // Wrapping off the last row scrolls nothing: row 0 is blanked instead.
              cursor_col <= '0;
              if (row_max) begin
                cursor_row <= '0;
                clr_idx    <= '0;
                state      <= CLR_ROW;
                char_ready <= 1'b0;
                busy       <= 1'b1;
              end else begin
                cursor_row <= cursor_row + RW'(1);
              end
            end
          end
        end
        default: state <= CLR_ALL;
      endcase
    end
  end

  logic [9:0]    dx, dy;
  logic          in_win;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  assign dx     = x - 10'(X0);
  assign dy     = y - 10'(Y0);
  assign in_win = (x >= 10'(X0)) && (dx < 10'(COLS * 8)) &&
                  (y >= 10'(Y0)) && (dy < 10'(ROWS * 16));
  assign raddr  = {RW'(dy >> 4), CW'(dx >> 3)};
  assign rdata  = mem[raddr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ascii_code  <= 8'h20;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
      if (!in_win)
        ascii_code <= 8'h20;
      else if (raddr == cur_idx && blink_phase && rdata == 8'h20)
        ascii_code <= 8'h5F;
      else
        ascii_code <= rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
`default_nettype none
// Directed bench for text_buffer_ctrl with a 4-cycle blink divider.
module tb_text_buffer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       busy;
  logic [9:0] x, y;
  logic [7:0] ascii_code;
  logic [4:0] cursor_col;
  logic [1:0] cursor_row;

  int total = 0;
  int bad   = 0;

  text_buffer_ctrl #(
    .COLS(32), .ROWS(4), .X0(192), .Y0(208), .BLINK_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy), .x(x), .y(y),
    .ascii_code(ascii_code), .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    while (!char_ready && n < 500) begin tick(); n++; end
    if (!char_ready) check("ready_timeout", 0, 1);
    char_in    = c;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    char_in    = 8'h00;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 1000) begin tick(); n++; end
  endtask

  task automatic rd_xy(input int px, input int py, output logic [7:0] v);
    x = 10'(px);
    y = 10'(py);
    tick();
    v = ascii_code;
  endtask

  task automatic rd(input int r, input int c, output logic [7:0] v);
    rd_xy(192 + c * 8, 208 + r * 16, v);
  endtask

  initial begin
    int n;
    int nbad;
    logic [7:0] v;
    logic [7:0] s [16];

    reset = 1'b1; char_in = 8'h00; char_valid = 1'b0; x = '0; y = '0;
    tick(); tick();
    check("rst_ready", char_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_ascii", ascii_code, 8'h20);
    check("rst_cursor", {cursor_row, cursor_col}, 7'd0);
    reset = 1'b0;
    busy_len(n);
    check("init_busy_len", n, 128);
    check("init_ready", char_ready, 1);

    nbad = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++)
        if (r != 0 || c != 0) begin
          rd(r, c, v);
          if (v !== 8'h20) nbad++;
        end
    check("init_blank", nbad, 0);

    // Blink on the blank cursor cell at (0,0)
    x = 10'd192; y = 10'd208;
    tick();
    for (int i = 0; i < 16; i++) begin s[i] = ascii_code; tick(); end
    nbad = 0;
    for (int i = 0; i < 12; i++)
      if ((s[i] == 8'h20 || s[i] == 8'h5F) && s[i+4] != s[i] &&
          (i >= 8 || s[i+8] == s[i])) nbad++;
    check("blink_alt", nbad, 12);

    send(8'h41);
    check("cur_after_41", {cursor_row, cursor_col}, {2'd0, 5'd1});
    rd(0, 0, v);
    check("cell00_41", v, 8'h41);
    send(8'hA1);
    rd(0, 1, v);
    check("cell01_A1", v, 8'hA1);
    send(8'h7F);
    send(8'h05);
    check("cur_noop_codes", {cursor_row, cursor_col}, {2'd0, 5'd2});

    send(8'h0C);
    check("clr_cursor", {cursor_row, cursor_col}, 7'd0);
    busy_len(n);
    check("clr_busy_len", n, 128);
    rd(0, 1, v);
    check("clr_cell01", v, 8'h20);

    for (int i = 0; i < 32; i++) send(8'h41);
    send(8'h42);
    check("cur_wrap_col", {cursor_row, cursor_col}, {2'd1, 5'd1});
    rd(1, 0, v);
    check("cell10_42", v, 8'h42);
    rd(0, 31, v);
    check("cell031_41", v, 8'h41);
    send(8'h0D);
    check("cur_newline", {cursor_row, cursor_col}, {2'd2, 5'd0});

    send(8'h08);
    check("bs_row_wrap", {cursor_row, cursor_col}, {2'd1, 5'd31});
    for (int i = 0; i < 31; i++) send(8'h08);
    check("bs_to_10", {cursor_row, cursor_col}, {2'd1, 5'd0});
    send(8'h08);
    check("bs_from_10", {cursor_row, cursor_col}, {2'd0, 5'd31});
    send(8'h0D);
    send(8'h0D);
    rd(0, 31, v);
    check("bs_cell031", v, 8'h20);
    rd(0, 30, v);
    check("bs_cell030", v, 8'h41);
    rd(1, 0, v);
    check("bs_cell10", v, 8'h20);
    send(8'h0D);
    for (int i = 0; i < 31; i++) send(8'h61);
    check("cur_331", {cursor_row, cursor_col}, {2'd3, 5'd31});

    send(8'h43);
    check("wrap_cursor", {cursor_row, cursor_col}, 7'd0);
    busy_len(n);
    check("row_busy_len", n, 32);
    nbad = 0;
    for (int c = 1; c < 32; c++) begin
      rd(0, c, v);
      if (v !== 8'h20) nbad++;
    end
    check("row0_blank", nbad, 0);
    rd(3, 0, v);
    check("cell30_kept", v, 8'h61);
    rd(3, 15, v);
    check("cell315_kept", v, 8'h61);

    send(8'h08);
    check("bs_at_origin", {cursor_row, cursor_col}, 7'd0);
    check("bs_origin_ready", char_ready, 1);
    rd(3, 31, v);
    check("cell331_kept", v, 8'h43);

    rd_xy(447, 271, v);
    check("edge_447_271", v, 8'h43);
    rd_xy(448, 271, v);
    check("out_x448", v, 8'h20);
    rd_xy(191, 208, v);
    check("out_x191", v, 8'h20);
    rd_xy(192, 207, v);
    check("out_y207", v, 8'h20);
    rd_xy(200, 272, v);
    check("out_y272", v, 8'h20);

    send(8'h5A);
    send(8'h0C);
    for (int i = 0; i < 50; i++) tick();
    check("mid_clr_busy", busy, 1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    busy_len(n);
    check("rst_mid_busy_len", n, 128);
    check("rst_mid_cursor", {cursor_row, cursor_col}, 7'd0);
    check("rst_mid_ready", char_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
